// File: rtl/dm_pkg.sv
// dm_pkg: shared opcodes, default widths and memory request type for the data-memory port arbiter
package dm_pkg;
    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam int DM_ADDR_W = 8;
    localparam int DM_DATA_W = 8;
    typedef struct packed {
        logic                 en;
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/dm_starve_ctr.sv
// dm_starve_ctr: counts consecutive denied DMA cycles and raises the forced-grant flag
module dm_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (!dma_req || dma_gnt) ? 4'd0 : (cnt_q == 4'(STARVE_LIMIT)) ? cnt_q : cnt_q + 4'd1;
        force_dma = dma_req && (cnt_q == 4'(STARVE_LIMIT));
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the MEM stage and a DMA/loader port
module dm_port_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W       = DM_ADDR_W,
    parameter int DATA_W       = DM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [3:0]        pipe_opcode,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic pipe_mem, pipe_st, force_dma, issue_dma, issue_pipe;
    logic rd_pipe_q, rd_pipe_d, rd_dma_q, rd_dma_d;
    logic [DATA_W-1:0] pipe_hold_q, pipe_hold_d, dma_hold_q, dma_hold_d;
    mem_req_t req;

    dm_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    always_comb begin
        pipe_mem = pipe_valid && (pipe_opcode == OP_LOAD || pipe_opcode == OP_STORE);
        pipe_st = pipe_opcode == OP_STORE;
        // a forced DMA grant takes the port and stalls whatever the MEM stage presents
        issue_dma = !rst && dma_req && (force_dma || !pipe_mem);
        issue_pipe = !rst && pipe_mem && !force_dma;
        req = issue_dma ? mem_req_t'{1'b1, dma_we, dma_addr, dma_wdata}
            : issue_pipe ? mem_req_t'{1'b1, pipe_st, pipe_addr, pipe_wdata} : '0;
        mem_en = req.en;
        mem_we = req.we;
        mem_addr = req.addr;
        mem_wdata = req.wdata;
        dma_gnt = issue_dma;
        pipe_stall = !rst && force_dma && pipe_mem;
        rd_pipe_d = issue_pipe && !pipe_st;
        rd_dma_d = issue_dma && !dma_we;
        pipe_rvalid = !rst && rd_pipe_q;
        dma_rvalid = !rst && rd_dma_q;
        pipe_rdata = rst ? '0 : pipe_rvalid ? mem_rdata : pipe_hold_q;
        dma_rdata = rst ? '0 : dma_rvalid ? mem_rdata : dma_hold_q;
        pipe_hold_d = pipe_rdata;
        dma_hold_d = dma_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe_q <= 1'b0;
            rd_dma_q <= 1'b0;
            pipe_hold_q <= '0;
            dma_hold_q <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            rd_dma_q <= rd_dma_d;
            pipe_hold_q <= pipe_hold_d;
            dma_hold_q <= dma_hold_d;
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: randomized scoreboard bench with a behavioural arbitration/memory reference model
module tb_dm_port_arbiter;
    import dm_pkg::*;
    localparam int LIM = 4;

    logic clk = 0, rst = 1;
    logic pipe_valid = 0, dma_req = 0, dma_we = 0;
    logic [3:0] pipe_opcode = 0;
    logic [7:0] pipe_addr = 0, pipe_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic pipe_stall, pipe_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [7:0] pipe_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    typedef struct { logic v; logic [3:0] op; logic [7:0] a, d; } pop_t;
    typedef struct { logic r, we; logic [7:0] a, d; } dop_t;
    typedef struct { int due; logic [7:0] d; } exp_t;
    pop_t pq[$];
    dop_t dq[$];
    exp_t pexp[$], dexp[$];
    logic [7:0] phold = 0, dhold = 0;
    int cyc = 0, total = 0, passed = 0;
    int stall_cnt = 0, en_cnt = 0, wait_n = 0, last_wait = 0;

    dm_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_opcode(pipe_opcode), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data memory: synchronous write, one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic ret(string name, logic v, logic [7:0] d, ref exp_t q[$], ref logic [7:0] hold);
        logic ev;
        logic [7:0] ed;
        ev = 0;
        ed = hold;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (!rst) begin ev = 1; ed = q[0].d; hold = q[0].d; end
            void'(q.pop_front());
        end
        if (rst) begin ed = 0; hold = 0; end
        chk(name, {23'd0, v, d}, {23'd0, ev, ed});
    endtask

    // monitor: pops expected read returns as they fall due
    always @(negedge clk) begin
        ret("pipe_ret", pipe_rvalid, pipe_rdata, pexp, phold);
        ret("dma_ret", dma_rvalid, dma_rdata, dexp, dhold);
    end

    int starve = 0;
    task automatic step();
        pop_t p;
        dop_t q;
        logic pm, fr, di, pi, st, w;
        logic [7:0] a, d;
        p = pq.size() > 0 ? pq[0] : '{1'b0, 4'd0, 8'd0, 8'd0};
        q = dq.size() > 0 ? dq[0] : '{1'b0, 1'b0, 8'd0, 8'd0};
        pipe_valid = p.v; pipe_opcode = p.op; pipe_addr = p.a; pipe_wdata = p.d;
        dma_req = q.r; dma_we = q.we; dma_addr = q.a; dma_wdata = q.d;
        @(negedge clk);
        #1;
        pm = p.v && (p.op == OP_LOAD || p.op == OP_STORE);
        fr = q.r && starve == LIM;
        di = !rst && q.r && (fr || !pm);
        pi = !rst && pm && !fr;
        st = !rst && pm && fr;
        w = di ? q.we : (pi && p.op == OP_STORE);
        a = di ? q.a : pi ? p.a : 8'd0;
        d = di ? q.d : pi ? p.d : 8'd0;
        chk("issue", {12'd0, dma_gnt, pipe_stall, mem_en, mem_we, mem_addr, mem_wdata},
                     {12'd0, di, st, di || pi, w, a, d});
        stall_cnt += int'(pipe_stall);
        en_cnt += int'(mem_en);
        if (q.r) wait_n++;
        if (dma_gnt) last_wait = wait_n;
        if (!q.r || dma_gnt) wait_n = 0;
        if (rst) begin
            pexp.delete(); dexp.delete(); starve = 0;
        end else begin
            if (di && q.we) ref_mem[q.a] = q.d;
            if (di && !q.we) dexp.push_back('{cyc + 1, ref_mem[q.a]});
            if (pi && p.op == OP_STORE) ref_mem[p.a] = p.d;
            if (pi && p.op == OP_LOAD) pexp.push_back('{cyc + 1, ref_mem[p.a]});
            starve = (!q.r || di) ? 0 : starve + 1;
            if (dq.size() > 0 && (!q.r || di)) void'(dq.pop_front());
            if (pq.size() > 0 && !st) void'(pq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int max);
        int n = 0;
        while ((pq.size() > 0 || dq.size() > 0) && n < max) begin step(); n++; end
        if (pq.size() > 0 || dq.size() > 0) begin
            total++;
            $display("FAIL drain: stimulus left after %0d cycles", max);
            pq.delete(); dq.delete();
        end
        step();
        step();
    endtask

    task automatic pp(logic [3:0] op, logic [7:0] a, logic [7:0] d);
        pq.push_back('{1'b1, op, a, d});
    endtask

    task automatic pd(logic r, logic we, logic [7:0] a, logic [7:0] d);
        dq.push_back('{r, we, a, d});
    endtask

    initial begin
        logic [3:0] ops [4] = '{OP_LOAD, OP_STORE, 4'b1001, 4'b1000};
        for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
        rst = 1; step(); step(); rst = 0;
        // pipeline stores then back-to-back loads
        stall_cnt = 0;
        pp(OP_STORE, 8'h01, 8'hA9); pp(OP_STORE, 8'h02, 8'h19); pp(OP_STORE, 8'h03, 8'h5D);
        pp(OP_LOAD, 8'h01, 0); pp(OP_LOAD, 8'h02, 0); pp(OP_LOAD, 8'h03, 0);
        run(50);
        chk("t1_no_stall", stall_cnt, 0);
        // DMA write then read on an idle pipeline
        pd(1, 1, 8'h01, 8'h40); pd(1, 0, 8'h01, 0);
        run(50);
        // DMA read held against a pipeline loading every cycle
        stall_cnt = 0; wait_n = 0; last_wait = 0;
        for (int i = 0; i < 8; i++) pp(OP_LOAD, 8'h03, 0);
        pd(1, 0, 8'h03, 0);
        run(50);
        chk("t3_force_cycle", last_wait, LIM + 1);
        chk("t3_stalls", stall_cnt, 1);
        // forced DMA write under a stalled load of the same address
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) pp(OP_LOAD, 8'h02, 0);
        pd(1, 1, 8'h02, 8'hFF);
        run(50);
        chk("t4_stalls", stall_cnt, 1);
        chk("t4_mem", ref_mem[8'h02], 8'hFF);
        // non-memory opcodes
        en_cnt = 0; stall_cnt = 0;
        pp(4'b1001, 8'h01, 8'h11); pp(4'b1000, 8'h02, 8'h22);
        run(20);
        chk("t5_no_en", en_cnt, 0);
        chk("t5_no_stall", stall_cnt, 0);
        // reset while a load is outstanding
        pp(OP_LOAD, 8'h03, 0);
        step();
        rst = 1; step(); rst = 0;
        step();
        pp(OP_LOAD, 8'h03, 0);
        run(20);
        // randomized traffic with address collisions
        for (int i = 0; i < 300; i++)
            pq.push_back('{($urandom % 4) != 0, ($urandom % 5 == 0) ? 4'($urandom) : ops[$urandom % 4],
                           8'($urandom % 8), 8'($urandom)});
        for (int i = 0; i < 100; i++)
            pd(($urandom % 3) != 0, 1'($urandom), 8'($urandom % 8), 8'($urandom));
        run(2000);
        chk("pending", pexp.size() + dexp.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
